layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Parametrised per-layer control sequencer for the CNN datapath. It replaces the fixed single-pass controller with a start/done-handshaked engine. The engine loops over `IC` input channels for each of `OC` output channels and optionally finishes with a pooling pass. It drives the channel-load, convolution, adder-tree, count-out and pool strobes of one layer and exposes the live channel indices to the address generators.

## Interface
- `IC`, default 3: input channels per output channel, ≥1.
- `OC`, default 4: output channels per layer, ≥1.
- `POOL_EN`, default 1: 1 runs a POOL phase after the last output channel; 0 skips it.
- `ICW`, default `$clog2(IC)`, min 1: width of `ic_idx`.
- `OCW`, default `$clog2(OC)`, min 1: width of `oc_idx`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle request to run one layer; sampled only in IDLE.
- `abort` in 1: synchronous abort; highest priority.
- `conv_done` in 1: convolution engine finished the current input channel.
- `tree_done` in 1: adder tree finished accumulating the current channel.
- `pool_done` in 1: pooling unit finished.
- `c_load` out 1: load current input channel.
- `conv` out 1: convolution active.
- `tree` out 1: accumulation active.
- `cout` out 1: write out the current output channel.
- `pool` out 1: pooling active.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle layer-complete pulse.
- `ic_idx` out `ICW`: current input channel.
- `oc_idx` out `OCW`: current output channel.

## Operation
- States: IDLE, CH_LOAD, CONV, TREE, COUT, POOL, DONE.
- Outputs are Moore, decoded from the state register only:
  - CH_LOAD drives `c_load`.
  - CONV drives `conv`.
  - TREE drives `tree`.
  - COUT drives `cout`.
  - POOL drives `pool`.
  - DONE drives `done`.
- Transitions:
  - IDLE: `start` → CH_LOAD, with `ic_idx` = `oc_idx` = 0. Otherwise stay.
  - CH_LOAD: always → CONV after 1 cycle.
  - CONV: hold until `conv_done`. Then → TREE if `IC` > 1, else → COUT.
  - TREE: hold until `tree_done`. Then:
    - if `ic_idx` == `IC`-1 → COUT;
    - otherwise `ic_idx`++ and → CH_LOAD.
  - COUT: 1 cycle, clears `ic_idx` to 0. Then:
    - if `oc_idx` == `OC`-1 → POOL when `POOL_EN`=1, else → DONE;
    - otherwise `oc_idx`++ and → CH_LOAD.
  - POOL: hold until `pool_done`, then → DONE.
  - DONE: 1 cycle, then → IDLE. `oc_idx` is cleared to 0 on exit.
- `abort`, when high, forces IDLE from any state on the next edge and clears both indices. It overrides `start` and every done input.
- Done inputs are ignored in any state that is not waiting for them. For example, `pool_done` during CONV has no effect.
- `start` outside IDLE is ignored; it is neither queued nor restarted.
- Indices never exceed `IC`-1 / `OC`-1. There is no wrap; the terminal compare selects the exit path.
- Unused or illegal state encodings → IDLE.

## Timing
- Reset values: state IDLE, all strobes 0, `busy`=0, `done`=0, `ic_idx`=0, `oc_idx`=0.
- Reset asserted mid-layer returns to these values immediately (asynchronous).
- `start` to `c_load` high: 1 cycle.
- Each done input is consumed on the edge where it is sampled high. The next state's strobe is visible in the following cycle.
- A done input held high for several cycles advances only one step per state visit.
  - Exception: in CONV with `IC`=1, it lands in COUT; COUT is single-cycle regardless.
- Minimum layer length, with every done input tied high:
  - `IC`=1, `OC`=1, `POOL_EN`=0: 4 cycles in states CH_LOAD, CONV, COUT, DONE.
  - General: `OC`·(2·`IC` + 1 + (`IC`>1 ? `IC` : 0)) + (`POOL_EN` ? 1 : 0) + 1 cycles.
- `done` is high exactly 1 cycle and `busy` drops in the same edge as DONE → IDLE.
  - A new `start` is accepted the cycle after `done`.

## Test plan
- **Reset and idle:** reset, no `start`, 10 cycles → all outputs 0, indices 0.
- **Minimal layer:** `IC`=1, `OC`=1, `POOL_EN`=0, all done inputs tied 1, pulse `start` → strobes `c_load`, `conv`, `cout`, `done` on 4 consecutive cycles, then idle. `tree` and `pool` never assert.
- **Full loop:** `IC`=3, `OC`=2, `POOL_EN`=1, done inputs returned 2 cycles after each strobe rises → `c_load` ×6 with `ic_idx` sequence 0,1,2,0,1,2, `cout` ×2 with `oc_idx` 0 then 1, `pool` once, single `done`.
- **Mid-layer abort:** same configuration, assert `abort` in TREE with `ic_idx`=1, `oc_idx`=1 → next cycle IDLE, indices 0, `busy`=0, no `done`. A new `start` restarts at `ic_idx`=0.
- **Spurious inputs:** `pool_done` and `tree_done` pulsed during CONV, and `start` pulsed during POOL → state unchanged, exactly one `done` per accepted `start`.
- **Mid-operation reset:** `rst_n` pulled low during POOL → outputs immediately at reset values. After release, `start` runs a full layer correctly.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: host handshake, phase strobes and live channel indices of one layer sequencer
interface layer_sequencer_if #(
   parameter int ICW = 2,
   parameter int OCW = 2
);
   logic start, abort, conv_done, tree_done, pool_done;
   logic c_load, conv, tree, cout, pool, busy, done;
   logic [ICW-1:0] ic_idx;
   logic [OCW-1:0] oc_idx;
   modport master (
      output start, abort, conv_done, tree_done, pool_done,
      input  c_load, conv, tree, cout, pool, busy, done, ic_idx, oc_idx
   );
   modport slave (
      input  start, abort, conv_done, tree_done, pool_done,
      output c_load, conv, tree, cout, pool, busy, done, ic_idx, oc_idx
   );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: start/done-handshaked loop over IC input x OC output channels with an optional pooling pass
module layer_sequencer #(
   parameter int IC      = 3,
   parameter int OC      = 4,
   parameter bit POOL_EN = 1'b1,
   parameter int ICW     = (IC > 1) ? $clog2(IC) : 1,
   parameter int OCW     = (OC > 1) ? $clog2(OC) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   layer_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CH_LOAD, CONV, TREE, COUT, POOL, DONE} state_t;
   localparam logic [ICW-1:0] IC_LAST = ICW'(IC - 1);
   localparam logic [OCW-1:0] OC_LAST = OCW'(OC - 1);
   state_t         state_q, state_d;
   logic [ICW-1:0] ic_idx_q, ic_idx_d;
   logic [OCW-1:0] oc_idx_q, oc_idx_d;
   logic           ic_last, oc_last;
   assign ic_last = ic_idx_q == IC_LAST;
   assign oc_last = oc_idx_q == OC_LAST;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ic_idx_q <= '0;
         oc_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         ic_idx_q <= ic_idx_d;
         oc_idx_q <= oc_idx_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      ic_idx_d = ic_idx_q;
      oc_idx_d = oc_idx_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d  = CH_LOAD;
            ic_idx_d = '0;
            oc_idx_d = '0;
         end
         CH_LOAD: state_d = CONV;
         CONV: if (bus.conv_done) state_d = (IC > 1) ? TREE : COUT;
         TREE: if (bus.tree_done) begin
            state_d  = ic_last ? COUT : CH_LOAD;
            ic_idx_d = ic_last ? ic_idx_q : ic_idx_q + ICW'(1);
         end
         COUT: begin
            ic_idx_d = '0;
            state_d  = oc_last ? (POOL_EN ? POOL : DONE) : CH_LOAD;
            oc_idx_d = oc_last ? oc_idx_q : oc_idx_q + OCW'(1);
         end
         POOL: if (bus.pool_done) state_d = DONE;
         DONE: begin
            state_d  = IDLE;
            oc_idx_d = '0;
         end
         default: begin
            state_d  = IDLE;
            ic_idx_d = '0;
            oc_idx_d = '0;
         end
      endcase
      if (bus.abort) begin
         state_d  = IDLE;
         ic_idx_d = '0;
         oc_idx_d = '0;
      end
   end
   assign bus.c_load = state_q == CH_LOAD;
   assign bus.conv   = state_q == CONV;
   assign bus.tree   = state_q == TREE;
   assign bus.cout   = state_q == COUT;
   assign bus.pool   = state_q == POOL;
   assign bus.done   = state_q == DONE;
   assign bus.busy   = state_q != IDLE;
   assign bus.ic_idx = ic_idx_q;
   assign bus.oc_idx = oc_idx_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench for a minimal (1x1, no pool) and a full (3x2, pool) sequencer
module tb_layer_sequencer;
   typedef struct packed {logic [1:0] kind; logic [1:0] ic; logic oc;} ev_t;
   localparam logic [1:0] K_LOAD = 2'd0, K_COUT = 2'd1, K_POOL = 2'd2, K_DONE = 2'd3;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   ev_t sb[$];
   logic [6:0] va_q[$];
   int b_cnt = 0;
   logic [2:0] prev_w = '0;
   logic prev_pool = 1'b0;
   always #5 clk = ~clk;
   layer_sequencer_if #(.ICW(1), .OCW(1)) ifa ();
   layer_sequencer_if #(.ICW(2), .OCW(1)) ifb ();
   layer_sequencer #(.IC(1), .OC(1), .POOL_EN(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   layer_sequencer #(.IC(3), .OC(2), .POOL_EN(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   function automatic logic [6:0] vec_a();
      return {ifa.busy, ifa.c_load, ifa.conv, ifa.tree, ifa.cout, ifa.pool, ifa.done};
   endfunction
   function automatic logic [6:0] vec_b();
      return {ifb.busy, ifb.c_load, ifb.conv, ifb.tree, ifb.cout, ifb.pool, ifb.done};
   endfunction
   task automatic push_layer();
      for (int o = 0; o < 2; o++) begin
         for (int i = 0; i < 3; i++) sb.push_back(ev_t'({K_LOAD, 2'(i), 1'(o)}));
         sb.push_back(ev_t'({K_COUT, 2'd0, 1'(o)}));
      end
      sb.push_back(ev_t'({K_POOL, 3'd0}));
      sb.push_back(ev_t'({K_DONE, 3'd0}));
   endtask
   // one cycle of dut_b: report the strobe event seen, then answer each wait state 2 cycles after it starts
   task automatic cycle_b(output bit got, output ev_t obs);
      logic [2:0] w;
      @(negedge clk);
      got = 1'b1;
      if (ifb.c_load) obs = ev_t'({K_LOAD, ifb.ic_idx, ifb.oc_idx});
      else if (ifb.cout) obs = ev_t'({K_COUT, 2'd0, ifb.oc_idx});
      else if (ifb.pool && !prev_pool) obs = ev_t'({K_POOL, 3'd0});
      else if (ifb.done) obs = ev_t'({K_DONE, 3'd0});
      else begin
         got = 1'b0;
         obs = '0;
      end
      prev_pool = ifb.pool;
      w = {ifb.conv, ifb.tree, ifb.pool};
      b_cnt = (w == 3'b000) ? 0 : (w == prev_w) ? b_cnt + 1 : 1;
      prev_w = w;
      ifb.conv_done = ifb.conv && b_cnt == 2;
      ifb.tree_done = ifb.tree && b_cnt == 2;
      ifb.pool_done = ifb.pool && b_cnt == 2;
   endtask
   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({vec_a(), vec_b(), ifb.ic_idx, ifb.oc_idx} !== '0) begin
         errors++;
         $display("FAIL reset_held a=%b b=%b ic=%0d oc=%0d want 0", vec_a(), vec_b(), ifb.ic_idx, ifb.oc_idx);
      end
      rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         checks++;
         if ({vec_a(), vec_b(), ifa.ic_idx, ifa.oc_idx, ifb.ic_idx, ifb.oc_idx} !== '0) begin
            errors++;
            $display("FAIL idle_%0d a=%b b=%b ic=%0d oc=%0d want 0", n, vec_a(), vec_b(), ifb.ic_idx, ifb.oc_idx);
         end
      end
   endtask
   task automatic test_minimal();
      logic [6:0] exp;
      ifa.conv_done = 1'b1;
      ifa.tree_done = 1'b1;
      ifa.pool_done = 1'b1;
      va_q.delete();
      va_q = '{7'b1100000, 7'b1010000, 7'b1000100, 7'b1000001, 7'b0000000, 7'b0000000};
      ifa.start = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         ifa.start = 1'b0;
         exp = va_q.pop_front();
         checks++;
         if ({vec_a(), ifa.ic_idx, ifa.oc_idx} !== {exp, 2'b00}) begin
            errors++;
            $display("FAIL minimal_%0d got %b ic=%0d oc=%0d want %b", n, vec_a(), ifa.ic_idx, ifa.oc_idx, exp);
         end
      end
   endtask
   task automatic test_back_to_back();
      logic [6:0] exp;
      va_q.delete();
      for (int l = 0; l < 2; l++) begin
         va_q.push_back(7'b1100000);
         va_q.push_back(7'b1010000);
         va_q.push_back(7'b1000100);
         va_q.push_back(7'b1000001);
         va_q.push_back(7'b0000000);
      end
      ifa.start = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         exp = va_q.pop_front();
         checks++;
         if (vec_a() !== exp) begin
            errors++;
            $display("FAIL back_to_back_%0d got %b want %b", n, vec_a(), exp);
         end
         ifa.start = (n == 4);
      end
   endtask
   task automatic test_full_loop(input bit spur);
      bit got, fin, pend;
      ev_t obs, exp;
      int dones;
      sb.delete();
      push_layer();
      dones = 0;
      fin = 1'b0;
      pend = 1'b0;
      ifb.start = 1'b1;
      for (int n = 0; n < 200 && !fin; n++) begin
         cycle_b(got, obs);
         ifb.start = 1'b0;
         if (pend) begin
            checks++;
            if (ifb.conv !== 1'b1) begin
               errors++;
               $display("FAIL spurious_conv_hold conv=%b want 1", ifb.conv);
            end
            pend = 1'b0;
         end
         if (got) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_extra got %b want none", obs);
            end else begin
               exp = sb.pop_front();
               if (obs !== exp) begin
                  errors++;
                  $display("FAIL sb_event got %b want %b", obs, exp);
               end
            end
            if (obs.kind == K_DONE) begin
               dones++;
               fin = 1'b1;
            end
         end
         if (spur && ifb.conv && b_cnt == 1) begin
            ifb.pool_done = 1'b1;
            ifb.tree_done = 1'b1;
            pend = 1'b1;
         end
         if (spur && ifb.pool) ifb.start = 1'b1;
      end
      checks++;
      if (sb.size() != 0 || !fin) begin
         errors++;
         $display("FAIL layer_end left=%0d finished=%0d want 0 and 1", sb.size(), fin);
      end
      for (int n = 0; n < 3; n++) begin
         cycle_b(got, obs);
         checks++;
         if (got || ifb.busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done_%0d event=%b busy=%b want none and 0", n, got, ifb.busy);
         end
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL done_count got %0d want 1", dones);
      end
   endtask
   task automatic test_abort();
      bit got, aborted;
      ev_t obs, exp;
      sb.delete();
      for (int i = 0; i < 3; i++) sb.push_back(ev_t'({K_LOAD, 2'(i), 1'b0}));
      sb.push_back(ev_t'({K_COUT, 3'd0}));
      sb.push_back(ev_t'({K_LOAD, 2'd0, 1'b1}));
      sb.push_back(ev_t'({K_LOAD, 2'd1, 1'b1}));
      aborted = 1'b0;
      ifb.start = 1'b1;
      for (int n = 0; n < 200 && !aborted; n++) begin
         cycle_b(got, obs);
         ifb.start = 1'b0;
         if (got) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL abort_extra got %b want none", obs);
            end else begin
               exp = sb.pop_front();
               if (obs !== exp) begin
                  errors++;
                  $display("FAIL abort_event got %b want %b", obs, exp);
               end
            end
         end
         if (ifb.tree && ifb.ic_idx == 2'd1 && ifb.oc_idx == 1'b1 && ifb.tree_done) begin
            ifb.abort = 1'b1;
            aborted = 1'b1;
         end
      end
      cycle_b(got, obs);
      ifb.abort = 1'b0;
      checks++;
      if ({vec_b(), ifb.ic_idx, ifb.oc_idx} !== '0 || sb.size() != 0 || !aborted) begin
         errors++;
         $display("FAIL abort_idle got %b ic=%0d oc=%0d left=%0d reached=%0d want 0", vec_b(), ifb.ic_idx, ifb.oc_idx, sb.size(), aborted);
      end
      for (int n = 0; n < 4; n++) begin
         cycle_b(got, obs);
         checks++;
         if (got || ifb.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet_%0d event=%b busy=%b want none and 0", n, got, ifb.busy);
         end
      end
      test_full_loop(1'b0);
   endtask
   task automatic test_mid_reset();
      bit got, in_pool;
      ev_t obs, exp;
      sb.delete();
      push_layer();
      in_pool = 1'b0;
      ifb.start = 1'b1;
      for (int n = 0; n < 200 && !in_pool; n++) begin
         cycle_b(got, obs);
         ifb.start = 1'b0;
         if (got) begin
            checks++;
            exp = sb.pop_front();
            if (obs !== exp) begin
               errors++;
               $display("FAIL reset_run_event got %b want %b", obs, exp);
            end
            in_pool = obs.kind == K_POOL;
         end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({vec_b(), ifb.ic_idx, ifb.oc_idx} !== '0 || !in_pool) begin
         errors++;
         $display("FAIL async_reset got %b ic=%0d oc=%0d reached_pool=%0d want 0", vec_b(), ifb.ic_idx, ifb.oc_idx, in_pool);
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_full_loop(1'b0);
   endtask
   initial begin
      {ifa.start, ifa.abort, ifa.conv_done, ifa.tree_done, ifa.pool_done} = '0;
      {ifb.start, ifb.abort, ifb.conv_done, ifb.tree_done, ifb.pool_done} = '0;
      test_reset();
      test_minimal();
      test_back_to_back();
      test_full_loop(1'b0);
      test_abort();
      test_full_loop(1'b1);
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
